immediate_encoder: RTL and testbench

Buffered RV32I instruction encoder: the inverse of the immediate generator. Accepts decoded instruction fields plus a 32-bit immediate over a valid/ready handshake, scatters the immediate into the opcode-specific bit positions, and range-checks it against the format's width and alignment. Results leave through a 2-entry output FIFO. Sits in the program-loader/test-stimulus path, feeding instruction memory images and cross-checking the decode side.

---
 rtl/immediate_encoder.sv | 168 ++++++++++++++++
 tb/tb_immediate_encoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_encoder.sv
// RV32I instruction encoder: scatters an immediate into its opcode-specific bit slots and buffers results in a 2-entry FIFO.
// Define IMM_RANGE_CHECK_EN to enable immediate range/alignment checking (out_err, err_count).
module immediate_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [31:0] enc_inst;
  logic        range_err;
  logic        enc_err;

  // A signed N-bit immediate fits when every bit from N-1 upward equals the sign.
  logic fits12, fits13, fits21;
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc_inst  = 32'h0;
    range_err = 1'b0;
    case (in_opcode)
      OP_ARITH: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_ARITH_IMM, OP_LOAD, OP_JALR: begin
        if (in_opcode == OP_ARITH_IMM && (in_funct3 == 3'b001 || in_funct3 == 3'b101)) begin
          enc_inst  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          range_err = |in_imm[31:5];
        end else begin
          enc_inst  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          range_err = ~fits12;
        end
      end
      OP_STORE: begin
        enc_inst  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        range_err = ~fits12;
      end
      OP_BRANCH: begin
        enc_inst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        range_err = ~fits13 | in_imm[0];
      end
      OP_JAL: begin
        enc_inst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        range_err = ~fits21 | in_imm[0];
      end
      OP_ECALL: begin
        enc_inst = 32'h00000073;
      end
      default: begin
        enc_inst  = 32'h0;
        range_err = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  assign enc_err = range_err;
`else
  logic unused_range_err;
  assign unused_range_err = range_err;
  assign enc_err = 1'b0;
`endif

  logic [1:0]  state_reg, state_next;
  logic [31:0] head_inst_reg, head_inst_next;
  logic        head_err_reg, head_err_next;
  logic [31:0] tail_inst_reg, tail_inst_next;
  logic        tail_err_reg, tail_err_next;
  logic        push, pop;

  assign in_ready  = (state_reg != ST_TWO);
  assign out_valid = (state_reg != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? head_inst_reg : 32'h0;
  assign out_err   = out_valid & head_err_reg;

  always_comb begin
    state_next     = state_reg;
    head_inst_next = head_inst_reg;
    head_err_next  = head_err_reg;
    tail_inst_next = tail_inst_reg;
    tail_err_next  = tail_err_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (push) begin
          state_next     = ST_ONE;
          head_inst_next = enc_inst;
          head_err_next  = enc_err;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_inst_next = enc_inst;
          head_err_next  = enc_err;
        end else if (push) begin
          state_next     = ST_TWO;
          tail_inst_next = enc_inst;
          tail_err_next  = enc_err;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Full: no push possible, so a pop just promotes the tail entry.
        if (pop) begin
          state_next     = ST_ONE;
          head_inst_next = tail_inst_reg;
          head_err_next  = tail_err_reg;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_EMPTY;
      head_inst_reg <= 32'h0;
      head_err_reg  <= 1'b0;
      tail_inst_reg <= 32'h0;
      tail_err_reg  <= 1'b0;
      enc_count     <= 16'h0;
      err_count     <= 8'h0;
    end else begin
      state_reg     <= state_next;
      head_inst_reg <= head_inst_next;
      head_err_reg  <= head_err_next;
      tail_inst_reg <= tail_inst_next;
      tail_err_reg  <= tail_err_next;
      if (push) begin
        enc_count <= enc_count + 16'd1;
        if (enc_err && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// Randomized scoreboard bench for immediate_encoder; follows IMM_RANGE_CHECK_EN the same way the design does.
module tb_immediate_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  immediate_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHECKS_ON = 1'b1;
`else
  localparam bit CHECKS_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];      // {err, inst}
  int unsigned m_enc = 0;
  int unsigned m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fields placed by arithmetic, range by signed-interval tests.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] r;
    logic [31:0] base;
    int signed s;
    bit bad;
    s    = imm;
    bad  = 0;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (op)
      7'h33: r = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      7'h13, 7'h03, 7'h67: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          r = (32'(f7) << 25) | ((imm % 32) << 20) | base | (32'(rd) << 7);
          bad = (imm > 31);
        end else begin
          r = ((imm % 4096) << 20) | base | (32'(rd) << 7);
          bad = (s < -2048) || (s > 2047);
        end
      end
      7'h23: begin
        r = (((imm / 32) % 128) << 25) | (32'(rs2) << 20) | base | ((imm % 32) << 7);
        bad = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        r = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) | (32'(rs2) << 20) | base
          | (((imm / 2) % 16) << 8) | (((imm / 2048) % 2) << 7);
        bad = (s < -4096) || (s > 4095) || (imm % 2 == 1);
      end
      7'h6F: begin
        r = (((imm / 1048576) % 2) << 31) | (((imm / 2) % 1024) << 21)
          | (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12) | (32'(rd) << 7) | 32'h6F;
        bad = (s < -1048576) || (s > 1048575) || (imm % 2 == 1);
      end
      7'h73: r = 32'h73;
      default: begin r = 0; bad = 1; end
    endcase
    return {bad & CHECKS_ON, r};
  endfunction

  // Monitor / scoreboard: occupancy, counters, and head contents every cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, sb.size() < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() > 0});
      chk("enc_count", {16'b0, enc_count}, m_enc % 65536);
      chk("err_count", {24'b0, err_count}, m_err);
      if (out_valid && sb.size() > 0) begin
        chk("out_inst", out_inst, sb[0][31:0]);
        chk("out_err", {31'b0, out_err}, {31'b0, sb[0][32]});
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) begin
        logic [32:0] e;
        e = model(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
        sb.push_back(e);
        m_enc++;
        if (e[32] && m_err < 255) m_err++;
      end
    end
  end

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    bit ok;
    n = 0;
    set_fields(op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) begin
      errors++; checks++;
      $display("FAIL send_timeout in_ready stayed 0 for %0d cycles", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete(); m_enc = 0; m_err = 0;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_err", {31'b0, out_err}, 0);
    chk("rst_enc_count", {16'b0, enc_count}, 0);
    chk("rst_err_count", {24'b0, err_count}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h73, 7'h5B};
  int bnd[14] = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097,
                  1048575, 1048576, -1048576, -1048577, 31, 32};

  function automatic logic [31:0] rand_imm();
    case ($urandom % 4)
      0: return 32'($urandom_range(40)) - 32'd20;
      1: return bnd[$urandom % 14];
      2: return $urandom;
      default: return 32'($urandom_range(2097151)) - 32'd1048576;
    endcase
  endfunction

  initial begin
    in_valid = 0; out_ready = 0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Test-plan vectors with literal expectations.
    out_ready = 1;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("tp_addi_inst", out_inst, 32'hFFF00093);
    chk("tp_addi_err", {31'b0, out_err}, 0);
    chk("tp_addi_cnt", {16'b0, enc_count}, 1);
    @(posedge clk); #1;
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    @(negedge clk);
    chk("tp_branch_inst", out_inst, 32'h00208463);
    @(posedge clk); #1;
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    @(negedge clk);
    chk("tp_jal_inst", out_inst, 32'h001000EF);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_fields(ops[$urandom % 9], 3'($urandom), 7'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), rand_imm());
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: two accepts fill the FIFO, third attempt stalls.
    out_ready = 0;
    send(7'h33, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 0);
    send(7'h33, 3'd7, 7'h20, 5'd6, 5'd7, 5'd8, 0);
    set_fields(7'h73, 0, 0, 0, 0, 0, 0);
    in_valid = 1;
    @(negedge clk);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("pop_edge_in_ready", {31'b0, in_ready}, 0);
    @(negedge clk);
    chk("after_pop_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while full.
    out_ready = 0;
    send(7'h73, 0, 0, 0, 0, 0, 0);
    send(7'h73, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Range-check vectors.
    out_ready = 1;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    @(negedge clk);
    chk("err_addi_flag", {31'b0, out_err}, {31'b0, CHECKS_ON});
    chk("err_addi_cnt", {24'b0, err_count}, CHECKS_ON ? 1 : 0);
    @(posedge clk); #1;
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    @(negedge clk);
    chk("err_branch_flag", {31'b0, out_err}, {31'b0, CHECKS_ON});
    @(negedge clk);
    chk("err_branch_cnt", {24'b0, err_count}, CHECKS_ON ? 2 : 0);
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) send(7'h7F, 0, 0, 0, 0, 0, $urandom);
    @(negedge clk);
    chk("err_saturate", {24'b0, err_count}, CHECKS_ON ? 255 : 0);
    @(posedge clk); #1;

    // enc_count wrap.
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 65536; i++) send(7'h73, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("enc_wrap", {16'b0, enc_count}, 0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
